// File: rtl/core101_pkg.sv
// Core101 fetch-stage shared types and defaults.
// Next-PC source encoding and address width/vector defaults.
package core101_pkg;

  localparam int          XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0004;
  localparam int          RAS_DEPTH_DEF    = 4;
  localparam int          PC_INC           = 4;

  typedef enum logic [1:0] {
    PC_SRC_INC,
    PC_SRC_PRED,
    PC_SRC_RAS,
    PC_SRC_CORR
  } pc_src_e;

  function automatic logic addr_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Circular return-address stack; top entry sits at ptr-1.
// A full push overwrites the oldest entry; push+pop replaces the top.
module pc_gen_ras
  import core101_pkg::*;
#(
  parameter int RAS_DEPTH = RAS_DEPTH_DEF,
  parameter int XLEN      = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] push_data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   ptr_d;
  logic [PW-1:0]   top_idx;
  logic [PW-1:0]   wr_idx;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            wr_en;
  logic            empty;

  assign top_idx = ptr_q - PW'(1);
  assign empty   = (cnt_q == '0);
  assign empty_o = empty;
  assign top_o   = mem_q[top_idx];

  // Pointer/count update and write slot for push, pop or replace.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i && !empty) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != CW'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (pop_i && !empty) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Stack pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; cleared on reset so top_o is never X.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Core101 fetch PC generator: correction > RAS > prediction > PC+4.
// Define CORE101_PC_MISALIGN_EN to trap misaligned targets to TRAP_VECTOR.
module pc_gen
  import core101_pkg::*;
#(
  parameter int            XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
  parameter int            RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic            clock_in,
  input  logic            reset_n_in,
  input  logic            pc_gen_stall_in,
  input  logic            pc_gen_correction_en_in,
  input  logic [XLEN-1:0] pc_gen_correction_in,
  input  logic            pc_gen_prediction_en_in,
  input  logic [XLEN-1:0] pc_gen_prediction_in,
  input  logic            pc_gen_call_in,
  input  logic            pc_gen_ret_in,
  output logic [XLEN-1:0] pc_gen_addr_out,
  output logic            pc_gen_valid_out,
  output logic            pc_gen_pred_out,
  output logic            pc_gen_ras_empty_out,
  output logic            pc_gen_misalign_out
);

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] addr_d;
  logic            valid_q;
  logic            pred_q;
  logic            pred_d;
  logic            mis_q;
  logic            mis_d;

  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] raw_tgt;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            redirect;
  logic            advance;
  logic            push;
  logic            pop;
  logic            mis;
  pc_src_e         src;

  assign pc_inc   = addr_q + XLEN'(PC_INC);
  assign redirect = valid_q && pc_gen_correction_en_in;
  assign advance  = valid_q && !pc_gen_correction_en_in
                  && !pc_gen_stall_in;
  assign push     = advance && pc_gen_call_in;
  assign pop      = advance && pc_gen_ret_in && !ras_empty;

  pc_gen_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .XLEN      (XLEN)
  ) u_ras (
    .clk_i       (clock_in),
    .rst_ni      (reset_n_in),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_inc),
    .top_o       (ras_top),
    .empty_o     (ras_empty)
  );

  // Pick the next-PC source by priority.
  always_comb begin
    src = PC_SRC_INC;
    unique case (1'b1)
      redirect: src = PC_SRC_CORR;
      pop:      src = PC_SRC_RAS;
      advance && pc_gen_prediction_en_in:
                src = PC_SRC_PRED;
      default:  src = PC_SRC_INC;
    endcase
  end

  // Source mux, then alignment handling of redirected targets.
  always_comb begin
    raw_tgt = pc_inc;
    unique case (src)
      PC_SRC_CORR: raw_tgt = pc_gen_correction_in;
      PC_SRC_RAS:  raw_tgt = ras_top;
      PC_SRC_PRED: raw_tgt = pc_gen_prediction_in;
      default:     raw_tgt = pc_inc;
    endcase
`ifdef CORE101_PC_MISALIGN_EN
    tgt = raw_tgt;
    mis = (src != PC_SRC_INC) && addr_misaligned(raw_tgt[1:0]);
`else
    tgt = raw_tgt & ~XLEN'(3);
    mis = 1'b0;
`endif
  end

  // Next-state for PC and status flags.
  always_comb begin
    addr_d = addr_q;
    pred_d = pred_q;
    mis_d  = 1'b0;
    if (redirect || advance) begin
      if (mis) begin
        addr_d = TRAP_VECTOR;
        pred_d = 1'b0;
        mis_d  = 1'b1;
      end else begin
        addr_d = tgt;
        pred_d = (src == PC_SRC_RAS) || (src == PC_SRC_PRED);
      end
    end
  end

  // PC register; the first edge after reset only raises valid.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      addr_q  <= RESET_VECTOR;
      valid_q <= 1'b0;
      pred_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= 1'b1;
      pred_q  <= pred_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_gen_addr_out      = addr_q;
  assign pc_gen_valid_out     = valid_q;
  assign pc_gen_pred_out      = pred_q;
  assign pc_gen_ras_empty_out = ras_empty;
  assign pc_gen_misalign_out  = mis_q;

endmodule
